// File: rtl/axis_pkt_fifo.sv
// AXI-Stream packet FIFO with frame commit/rollback (FRAME_MODE=1) or cut-through
// (FRAME_MODE=0), a first-word-fall-through output register and occupancy status.
module axis_pkt_fifo #(
  parameter int DATA_WIDTH          = 8,
  parameter int FIFO_DEPTH          = 256,
  parameter int FRAME_MODE          = 1,
  parameter int ALMOST_FULL_MARGIN  = 16,
  parameter int ALMOST_EMPTY_MARGIN = 16,
  localparam int ADDR_WIDTH         = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [ADDR_WIDTH:0]   fill_count,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  frame_drop
);
  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = PW'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0] PTR_ONE = PW'(1);
  localparam bit FRAME = (FRAME_MODE != 0);

  // Handshakes: a beat transfers on a rising clk edge when tvalid && tready are both
  // high; tvalid never depends on tready, and data/last are held while tvalid && !tready.

  typedef enum logic [1:0] {IDLE, WRITE, DROP} state_t;
  state_t state;

  logic [DATA_WIDTH:0] mem [FIFO_DEPTH];
  logic [ADDR_WIDTH:0] wr_ptr, wr_commit, rd_ptr, rd_fetch, frame_cnt;
  logic [ADDR_WIDTH:0] free_cnt, committed_cnt;
  logic                ready_en, full, wr_accept, wr_en, commit;
  logic                s1_valid, out_valid;
  logic [DATA_WIDTH:0] s1_data, out_data;
  logic                pop, pop_last, s2_load, fetch;

  assign fill_count    = wr_ptr - rd_ptr;
  assign full          = (fill_count == DEPTH_W);
  assign s_axis_tready = ready_en && (FRAME || !full);
  assign wr_accept     = s_axis_tvalid && s_axis_tready;
  assign wr_en         = wr_accept && !full && !(FRAME && state == DROP);
  assign commit        = FRAME && wr_en && s_axis_tlast && !s_axis_tuser;

  assign m_axis_tvalid = out_valid;
  assign m_axis_tdata  = out_data[DATA_WIDTH-1:0];
  assign m_axis_tlast  = out_data[DATA_WIDTH];
  assign pop           = out_valid && m_axis_tready;
  assign pop_last      = FRAME && pop && out_data[DATA_WIDTH];
  assign s2_load       = s1_valid && (!out_valid || pop);
  // Only committed entries are fetched, so frame mode never exposes a partial frame.
  assign fetch         = (rd_fetch != wr_commit) && (!s1_valid || s2_load) &&
                         (!FRAME || frame_cnt != '0);

  assign free_cnt      = DEPTH_W - fill_count;
  assign committed_cnt = wr_commit - rd_ptr;
  assign almost_full   = int'(free_cnt) <= ALMOST_FULL_MARGIN;
  assign almost_empty  = int'(committed_cnt) <= ALMOST_EMPTY_MARGIN;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tdata};
  end

  // Write side: speculative wr_ptr, wr_commit moves only on a good tlast.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      wr_commit  <= '0;
      ready_en   <= 1'b0;
      frame_drop <= 1'b0;
    end else begin
      ready_en   <= 1'b1;
      frame_drop <= 1'b0;
      if (!FRAME) begin
        if (wr_accept) begin
          wr_ptr    <= wr_ptr + PTR_ONE;
          wr_commit <= wr_ptr + PTR_ONE;
        end
      end else if (wr_accept) begin
        case (state)
          DROP: begin
            if (s_axis_tlast) begin
              frame_drop <= 1'b1;
              state      <= IDLE;
            end
          end
          default: begin
            if (full) begin
              // Overflow: discard the frame so far and swallow the rest of it.
              wr_ptr     <= wr_commit;
              frame_drop <= s_axis_tlast;
              state      <= s_axis_tlast ? IDLE : DROP;
            end else if (s_axis_tlast && s_axis_tuser) begin
              wr_ptr     <= wr_commit;
              frame_drop <= 1'b1;
              state      <= IDLE;
            end else if (s_axis_tlast) begin
              wr_ptr    <= wr_ptr + PTR_ONE;
              wr_commit <= wr_ptr + PTR_ONE;
              state     <= IDLE;
            end else begin
              wr_ptr <= wr_ptr + PTR_ONE;
              state  <= WRITE;
            end
          end
        endcase
      end
    end
  end

  // Read side: RAM read stage (s1) feeding the FWFT output register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr    <= '0;
      rd_fetch  <= '0;
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      frame_cnt <= '0;
    end else begin
      if (fetch) begin
        s1_data  <= mem[rd_fetch[ADDR_WIDTH-1:0]];
        rd_fetch <= rd_fetch + PTR_ONE;
      end
      if (fetch) s1_valid <= 1'b1;
      else if (s2_load) s1_valid <= 1'b0;
      if (s2_load) begin
        out_data  <= s1_data;
        out_valid <= 1'b1;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      if (commit && !pop_last) frame_cnt <= frame_cnt + PTR_ONE;
      else if (!commit && pop_last) frame_cnt <= frame_cnt - PTR_ONE;
    end
  end
endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Bench for axis_pkt_fifo: one frame-mode and one cut-through instance (depth 16,
// margins 4) checked against per-instance expected-beat queues.
module tb_axis_pkt_fifo;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam logic [18:0] RST_VEC = {1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [DW-1:0] f_sdata, f_mdata, c_sdata, c_mdata;
  logic f_svalid, f_sready, f_slast, f_suser, f_mvalid, f_mready, f_mlast;
  logic c_svalid, c_sready, c_slast, c_suser, c_mvalid, c_mready, c_mlast;
  logic [AW:0] f_fill, c_fill;
  logic f_afull, f_aempty, f_drop, c_afull, c_aempty, c_drop;

  int checks = 0;
  int errors = 0;
  int c_pops = 0;
  bit rand_on = 1'b0;
  logic [DW:0] f_exp_q[$];
  logic [DW:0] c_exp_q[$];

  axis_pkt_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(16), .FRAME_MODE(1),
    .ALMOST_FULL_MARGIN(4), .ALMOST_EMPTY_MARGIN(4)) dut_f (
    .clk(clk), .reset_n(rst_n),
    .s_axis_tdata(f_sdata), .s_axis_tvalid(f_svalid), .s_axis_tready(f_sready),
    .s_axis_tlast(f_slast), .s_axis_tuser(f_suser),
    .m_axis_tdata(f_mdata), .m_axis_tvalid(f_mvalid), .m_axis_tready(f_mready),
    .m_axis_tlast(f_mlast), .fill_count(f_fill), .almost_full(f_afull),
    .almost_empty(f_aempty), .frame_drop(f_drop));

  axis_pkt_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(16), .FRAME_MODE(0),
    .ALMOST_FULL_MARGIN(4), .ALMOST_EMPTY_MARGIN(4)) dut_c (
    .clk(clk), .reset_n(rst_n),
    .s_axis_tdata(c_sdata), .s_axis_tvalid(c_svalid), .s_axis_tready(c_sready),
    .s_axis_tlast(c_slast), .s_axis_tuser(c_suser),
    .m_axis_tdata(c_mdata), .m_axis_tvalid(c_mvalid), .m_axis_tready(c_mready),
    .m_axis_tlast(c_mlast), .fill_count(c_fill), .almost_full(c_afull),
    .almost_empty(c_aempty), .frame_drop(c_drop));

  // Scoreboards: a beat seen valid&&ready at negedge is popped on the next posedge.
  always @(negedge clk) begin
    logic [DW:0] exp_b;
    if (rst_n && f_mvalid && f_mready) begin
      checks++;
      if (f_exp_q.size() == 0) begin
        errors++;
        $display("FAIL f_beat got %h exp none", {f_mlast, f_mdata});
      end else begin
        exp_b = f_exp_q.pop_front();
        if ({f_mlast, f_mdata} !== exp_b) begin
          errors++;
          $display("FAIL f_beat got %h exp %h", {f_mlast, f_mdata}, exp_b);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [DW:0] exp_b;
    if (rst_n && c_mvalid && c_mready) begin
      checks++;
      c_pops++;
      if (c_exp_q.size() == 0) begin
        errors++;
        $display("FAIL c_beat got %h exp none", {c_mlast, c_mdata});
      end else begin
        exp_b = c_exp_q.pop_front();
        if ({c_mlast, c_mdata} !== exp_b) begin
          errors++;
          $display("FAIL c_beat got %h exp %h", {c_mlast, c_mdata}, exp_b);
        end
      end
    end
  end

  // Drivers: entered and left at posedge+1.
  task automatic send_f(input logic [DW-1:0] d, input logic last, input logic user);
    int n;
    f_sdata = d; f_slast = last; f_suser = user; f_svalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!f_sready && n < 50) begin n++; @(negedge clk); end
    if (!f_sready) begin
      checks++; errors++;
      $display("FAIL f_send_timeout ready %b exp 1", f_sready);
    end
    @(posedge clk); #1;
    f_svalid = 1'b0; f_slast = 1'b0; f_suser = 1'b0;
  endtask

  task automatic send_c(input logic [DW-1:0] d, input logic last);
    int n;
    c_sdata = d; c_slast = last; c_svalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!c_sready && n < 50) begin n++; @(negedge clk); end
    if (!c_sready) begin
      checks++; errors++;
      $display("FAIL c_send_timeout ready %b exp 1", c_sready);
    end
    @(posedge clk); #1;
    c_svalid = 1'b0; c_slast = 1'b0;
  endtask

  task automatic test_reset();
    logic [18:0] got;
    rst_n = 1'b0;
    f_sdata = '0; f_svalid = 1'b0; f_slast = 1'b0; f_suser = 1'b0; f_mready = 1'b1;
    c_sdata = '0; c_svalid = 1'b0; c_slast = 1'b0; c_suser = 1'b0; c_mready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    got = {f_sready, f_mvalid, f_mlast, f_mdata, f_fill, f_afull, f_aempty, f_drop};
    checks++;
    if (got !== RST_VEC) begin errors++; $display("FAIL f_reset_vals got %h exp %h", got, RST_VEC); end
    got = {c_sready, c_mvalid, c_mlast, c_mdata, c_fill, c_afull, c_aempty, c_drop};
    checks++;
    if (got !== RST_VEC) begin errors++; $display("FAIL c_reset_vals got %h exp %h", got, RST_VEC); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ({f_sready, c_sready} !== 2'b00) begin
      errors++; $display("FAIL ready_before_edge got %b exp 00", {f_sready, c_sready});
    end
    @(posedge clk); #1;
    checks++;
    if ({f_sready, c_sready} !== 2'b11) begin
      errors++; $display("FAIL ready_after_edge got %b exp 11", {f_sready, c_sready});
    end
  endtask

  task automatic test_frame_commit();
    logic ok;
    for (int i = 1; i <= 5; i++) f_exp_q.push_back({(i == 5), 8'(i)});
    for (int i = 1; i <= 5; i++) send_f(8'(i), i == 5, 1'b0);
    checks++;
    if (f_mvalid !== 1'b0) begin errors++; $display("FAIL commit_lat0 got %b exp 0", f_mvalid); end
    checks++;
    if (f_aempty !== 1'b0) begin errors++; $display("FAIL commit_aempty got %b exp 0", f_aempty); end
    @(posedge clk); #1;
    checks++;
    if (f_mvalid !== 1'b0) begin errors++; $display("FAIL commit_lat1 got %b exp 0", f_mvalid); end
    @(posedge clk); #1;
    checks++;
    if (f_mvalid !== 1'b1) begin errors++; $display("FAIL commit_lat2 got %b exp 1", f_mvalid); end
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (f_mvalid !== 1'b1) ok = 1'b0;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL commit_back_to_back got gap exp none"); end
    @(posedge clk); #1;
    checks++;
    if ({f_mvalid, f_fill} !== 6'd0 || f_exp_q.size() != 0) begin
      errors++;
      $display("FAIL commit_end got valid %b fill %0d left %0d exp 0 0 0", f_mvalid, f_fill, f_exp_q.size());
    end
  endtask

  task automatic test_frame_rollback();
    logic ok;
    int n;
    for (int i = 0; i < 6; i++) begin
      send_f(8'h60 + 8'(i), i == 5, i == 5);
      if (i == 4) begin
        checks++;
        if (f_fill !== 5'd5) begin errors++; $display("FAIL rollback_fill5 got %0d exp 5", f_fill); end
      end
    end
    checks++;
    if ({f_drop, f_fill} !== {1'b1, 5'd0}) begin
      errors++; $display("FAIL rollback_drop got drop %b fill %0d exp 1 0", f_drop, f_fill);
    end
    @(posedge clk); #1;
    checks++;
    if (f_drop !== 1'b0) begin errors++; $display("FAIL rollback_pulse got %b exp 0", f_drop); end
    ok = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (f_mvalid !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL rollback_no_valid got 1 exp 0"); end
    f_exp_q.push_back({1'b0, 8'h10});
    f_exp_q.push_back({1'b0, 8'h11});
    f_exp_q.push_back({1'b1, 8'h12});
    send_f(8'h10, 1'b0, 1'b0);
    send_f(8'h11, 1'b0, 1'b0);
    send_f(8'h12, 1'b1, 1'b0);
    n = 0;
    while (f_exp_q.size() != 0 && n < 30) begin @(posedge clk); #1; n++; end
    checks++;
    if (f_exp_q.size() != 0 || f_fill !== 5'd0) begin
      errors++; $display("FAIL rollback_next_frame got left %0d fill %0d exp 0 0", f_exp_q.size(), f_fill);
    end
  endtask

  task automatic test_frame_oversize();
    logic ok;
    int n;
    for (int i = 0; i < 20; i++) begin
      send_f(8'h20 + 8'(i), i == 19, 1'b0);
      if (i == 15) begin
        checks++;
        if ({f_fill, f_afull} !== {5'd16, 1'b1}) begin
          errors++; $display("FAIL oversize_full got fill %0d af %b exp 16 1", f_fill, f_afull);
        end
      end
    end
    checks++;
    if ({f_drop, f_fill} !== {1'b1, 5'd0}) begin
      errors++; $display("FAIL oversize_drop got drop %b fill %0d exp 1 0", f_drop, f_fill);
    end
    ok = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (f_mvalid !== 1'b0 || f_drop !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL oversize_quiet got activity exp none"); end
    f_exp_q.push_back({1'b0, 8'h30});
    f_exp_q.push_back({1'b0, 8'h31});
    f_exp_q.push_back({1'b1, 8'h32});
    send_f(8'h30, 1'b0, 1'b0);
    send_f(8'h31, 1'b0, 1'b0);
    send_f(8'h32, 1'b1, 1'b0);
    n = 0;
    while (f_exp_q.size() != 0 && n < 30) begin @(posedge clk); #1; n++; end
    checks++;
    if (f_exp_q.size() != 0 || f_fill !== 5'd0) begin
      errors++; $display("FAIL oversize_next_frame got left %0d fill %0d exp 0 0", f_exp_q.size(), f_fill);
    end
  endtask

  task automatic test_cut_full();
    logic ok;
    int n;
    c_mready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      c_exp_q.push_back({(i == 15), 8'h40 + 8'(i)});
      send_c(8'h40 + 8'(i), i == 15);
      checks++;
      if (c_fill !== 5'(i + 1) || c_afull !== (i >= 11)) begin
        errors++;
        $display("FAIL cut_fill_af got fill %0d af %b exp %0d %b", c_fill, c_afull, i + 1, (i >= 11));
      end
    end
    checks++;
    if (c_sready !== 1'b0) begin errors++; $display("FAIL cut_ready_full got %b exp 0", c_sready); end
    c_exp_q.push_back({1'b0, 8'h50});
    ok = 1'b1;
    fork
      send_c(8'h50, 1'b0);
      begin
        repeat (3) begin
          @(negedge clk);
          if (c_sready || c_fill !== 5'd16 || !c_mvalid || {c_mlast, c_mdata} !== 9'h040) ok = 1'b0;
        end
        @(posedge clk); #1;
        c_mready = 1'b1;
      end
    join
    checks++;
    if (!ok) begin errors++; $display("FAIL cut_stall_hold got changed exp held"); end
    n = 0;
    while (c_exp_q.size() != 0 && n < 60) begin @(posedge clk); #1; n++; end
    checks++;
    if (c_exp_q.size() != 0 || c_fill !== 5'd0 || c_aempty !== 1'b1) begin
      errors++;
      $display("FAIL cut_drain got left %0d fill %0d ae %b exp 0 0 1", c_exp_q.size(), c_fill, c_aempty);
    end
  endtask

  task automatic test_cut_random();
    logic [DW-1:0] d;
    logic l;
    int gap;
    int start;
    int n;
    start = c_pops;
    rand_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          gap = $urandom_range(0, 2);
          repeat (gap) begin @(posedge clk); #1; end
          d = 8'($urandom_range(0, 255));
          l = 1'($urandom_range(0, 1));
          c_exp_q.push_back({l, d});
          send_c(d, l);
        end
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(posedge clk); #1;
          c_mready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    c_mready = 1'b1;
    n = 0;
    while (c_exp_q.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
    checks++;
    if (c_exp_q.size() != 0 || (c_pops - start) != 100 || c_fill !== 5'd0) begin
      errors++;
      $display("FAIL cut_random got left %0d pops %0d fill %0d exp 0 100 0",
               c_exp_q.size(), c_pops - start, c_fill);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [18:0] got;
    logic ok;
    int n;
    c_mready = 1'b0;
    for (int i = 0; i < 7; i++) send_f(8'h70 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) send_c(8'h78 + 8'(i), 1'b0);
    checks++;
    if ({f_fill, c_fill} !== {5'd7, 5'd7}) begin
      errors++; $display("FAIL mid_fill got %0d %0d exp 7 7", f_fill, c_fill);
    end
    #2;
    rst_n = 1'b0;
    #1;
    got = {f_sready, f_mvalid, f_mlast, f_mdata, f_fill, f_afull, f_aempty, f_drop};
    checks++;
    if (got !== RST_VEC) begin errors++; $display("FAIL f_mid_reset got %h exp %h", got, RST_VEC); end
    got = {c_sready, c_mvalid, c_mlast, c_mdata, c_fill, c_afull, c_aempty, c_drop};
    checks++;
    if (got !== RST_VEC) begin errors++; $display("FAIL c_mid_reset got %h exp %h", got, RST_VEC); end
    c_exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    c_mready = 1'b1;
    f_exp_q.push_back({1'b0, 8'hAA});
    f_exp_q.push_back({1'b1, 8'hBB});
    send_f(8'hAA, 1'b0, 1'b0);
    send_f(8'hBB, 1'b1, 1'b0);
    ok = 1'b1;
    n = 0;
    while (f_exp_q.size() != 0 && n < 30) begin
      @(posedge clk); #1; n++;
      if (c_mvalid !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (f_exp_q.size() != 0 || f_fill !== 5'd0) begin
      errors++; $display("FAIL post_reset_frame got left %0d fill %0d exp 0 0", f_exp_q.size(), f_fill);
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL c_post_reset_empty got valid exp 0"); end
  endtask

  initial begin
    test_reset();
    test_frame_commit();
    test_frame_rollback();
    test_frame_oversize();
    test_cut_full();
    test_cut_random();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    checks++;
    errors++;
    $display("FAIL watchdog got timeout exp completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axis_pkt_fifo.md
Name: axis_pkt_fifo

Overview:
- Single-clock AXI-Stream packet FIFO that buffers Ethernet frames between the MAC and the UDP/IP layers.
- Generalises the bad-packet drop/latch scheme into tlast/tuser-driven frame commit and rollback.
- Selectable store-and-forward (frame) or cut-through mode; parametrised width, depth and thresholds.
- First-word-fall-through output with occupancy status.

Parameters:
- DATA_WIDTH, 8: tdata width in bits.
- FIFO_DEPTH, 256: entries; must be a power of two ≥ 4. ADDR_WIDTH = log2(FIFO_DEPTH).
- FRAME_MODE, 1: 1 = store-and-forward with drop; 0 = cut-through, tuser ignored.
- ALMOST_FULL_MARGIN, 16: almost_full asserts when free entries ≤ margin.
- ALMOST_EMPTY_MARGIN, 16: almost_empty asserts when committed entries ≤ margin.

Ports:
- clk, in, 1: single clock.
- reset_n, in, 1: asynchronous, active-low reset.
- s_axis_tdata, in, DATA_WIDTH: write data.
- s_axis_tvalid, in, 1: write beat valid.
- s_axis_tready, out, 1: FIFO accepts the beat.
- s_axis_tlast, in, 1: last beat of frame.
- s_axis_tuser, in, 1: bad-frame flag, sampled on the tlast beat only.
- m_axis_tdata, out, DATA_WIDTH: read data.
- m_axis_tvalid, out, 1: read beat valid.
- m_axis_tready, in, 1: downstream accepts the beat.
- m_axis_tlast, out, 1: last beat of frame.
- fill_count, out, ADDR_WIDTH+1: entries held, including uncommitted entries.
- almost_full, out, 1: free entries ≤ ALMOST_FULL_MARGIN.
- almost_empty, out, 1: committed entries ≤ ALMOST_EMPTY_MARGIN.
- frame_drop, out, 1: one-cycle pulse when a frame is discarded.

Behaviour:
- Storage is DATA_WIDTH+1 bits wide ({tlast, tdata}).
- Pointers are ADDR_WIDTH+1 bits, with the MSB used for wrap.
- Three pointers: wr_ptr (speculative), wr_commit, rd_ptr.
- full = (wr_ptr − rd_ptr) == FIFO_DEPTH.
- Reset, asynchronous, while reset_n = 0:
  - all pointers, frame counter, output register and drop state cleared;
  - outputs: s_axis_tready = 0, m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0, fill_count = 0, almost_full = 0, almost_empty = 1, frame_drop = 0;
  - s_axis_tready rises on the first clk edge after deassertion;
  - reset mid-frame discards all contents, partial frames included.
- Write, cut-through (FRAME_MODE = 0):
  - s_axis_tready = !full.
  - An accepted beat advances wr_ptr and wr_commit together.
- Write, frame mode (FRAME_MODE = 1):
  - s_axis_tready = 1 unless in DROP state and ready is re-checked (see below); in practice s_axis_tready = !reset.
  - FSM states: IDLE, WRITE, DROP.
  - IDLE→WRITE on the first accepted beat. Beats are written at wr_ptr and advance it.
  - tlast accepted with tuser = 0: wr_commit ← wr_ptr+1, frame counter increments, next state IDLE.
  - tlast accepted with tuser = 1: wr_ptr ← wr_commit (rollback), frame_drop pulses the next cycle, next state IDLE.
  - Beat accepted while full: nothing is written, wr_ptr ← wr_commit, state → DROP.
  - DROP: beats are accepted and discarded until tlast. On tlast, frame_drop pulses and state → IDLE.
  - A single-beat frame (tlast on first beat) commits in one cycle.
  - Frames longer than FIFO_DEPTH are always dropped; the FIFO never deadlocks.
- Read (FWFT):
  - Cut-through: m_axis_tvalid is asserted when committed data exists.
  - Frame mode: m_axis_tvalid additionally requires frame counter > 0, or the current output frame already in progress.
  - Latency: beat/commit accepted at edge N → m_axis_tvalid high after edge N+2 (one RAM-read cycle, one output-register cycle).
  - The output register plus prefetch sustains one beat per cycle while m_axis_tready = 1.
  - Holding rule: tdata/tlast are held stable while tvalid = 1 and tready = 0.
  - Popping a beat with tlast = 1 decrements the frame counter.
  - Commit and pop-of-tlast in the same cycle leave the counter unchanged.
- Status:
  - fill_count = wr_ptr − rd_ptr, mod 2^(ADDR_WIDTH+1), registered and updated the cycle after the event.
  - Simultaneous write and read leave fill_count unchanged.
  - Rollback subtracts the rolled-back entries in the same cycle.
  - Entries still in the output register count as held until popped.
  - Wrap-around: pointer MSB toggles every FIFO_DEPTH entries; full/empty stay correct across repeated wraps.

Test Plan (FIFO_DEPTH = 16, DATA_WIDTH = 8, margins = 4):
- Frame mode, 5-beat frame 0x01–0x05, tuser = 0, m_axis_tready = 1 → m_axis_tvalid rises 2 cycles after the tlast beat; 0x01–0x05 out back-to-back with tlast on 0x05; fill_count returns to 0.
- Frame mode, 6-beat frame with tuser = 1 on tlast → frame_drop pulses once; fill_count returns to 0; m_axis_tvalid never asserts; the next good frame is output intact.
- Frame mode, 20-beat frame → all 20 beats accepted; frame_drop pulses after beat 20; FIFO empty; a following 3-beat frame passes.
- Cut-through, 16 writes with m_axis_tready = 0 → s_axis_tready falls after the 16th; fill_count = 16; almost_full asserted from fill_count = 12; the 17th beat is stalled, not lost.
- Cut-through, 100 random beats with random tvalid/tready → output equals input in order; ≥ 6 pointer wraps; no beat duplicated or lost.
- reset_n pulsed low mid-frame with 7 entries held → all outputs at reset values immediately; post-reset frame 0xAA, 0xBB output correctly.
